// File: rtl/jelly2_wishbone_rr_arbiter_if.sv
// Bus bundle for the round-robin WISHBONE arbiter: per-master s_ lanes plus the shared m_ port.
// The slave modport is the arbiter's view; master is the view of whoever drives the lanes.
interface jelly2_wishbone_rr_arbiter_if #(
  parameter int NUM_MASTERS  = 2,
  parameter int WB_ADR_WIDTH = 27,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
  logic [NUM_MASTERS-1:0][WB_ADR_WIDTH-1:0] s_wb_adr_i;
  logic [NUM_MASTERS-1:0][WB_DAT_WIDTH-1:0] s_wb_dat_i;
  logic [WB_DAT_WIDTH-1:0]                  s_wb_dat_o;
  logic [NUM_MASTERS-1:0]                   s_wb_we_i;
  logic [NUM_MASTERS-1:0][WB_SEL_WIDTH-1:0] s_wb_sel_i;
  logic [NUM_MASTERS-1:0]                   s_wb_stb_i;
  logic [NUM_MASTERS-1:0]                   s_wb_ack_o;

  logic [WB_ADR_WIDTH-1:0]                  m_wb_adr_o;
  logic [WB_DAT_WIDTH-1:0]                  m_wb_dat_o;
  logic                                     m_wb_we_o;
  logic [WB_SEL_WIDTH-1:0]                  m_wb_sel_o;
  logic                                     m_wb_stb_o;
  logic [WB_DAT_WIDTH-1:0]                  m_wb_dat_i;
  logic                                     m_wb_ack_i;

  modport slave (
    input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o,
    output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
    input  m_wb_dat_i, m_wb_ack_i
  );

  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    input  s_wb_dat_o, s_wb_ack_o,
    input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
    output m_wb_dat_i, m_wb_ack_i
  );
endinterface

// File: rtl/jelly2_wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one WISHBONE port among NUM_MASTERS masters, grant held until ack.
// Optional watchdog that fakes an all-ones ack on a stuck slave: define JELLY2_WB_ARB_TIMEOUT_EN.
module jelly2_wishbone_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int WB_ADR_WIDTH   = 27,
  parameter int WB_DAT_WIDTH   = 32,
  parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           reset,
  input  logic                           clk,
  jelly2_wishbone_rr_arbiter_if.slave    bus,
  output logic                           grant_valid,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           timeout
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] next_id;
  logic [ID_W-1:0] lane;
  logic            busy;
  logic            lane_stb;
  logic            real_ack;
  logic            fire;
  logic            done;

  // Rotating-priority scan starting just after the last completed master.
  always_comb begin
    logic            hit;
    int              idx;
    logic [ID_W-1:0] cand;
    hit     = 1'b0;
    idx     = 0;
    cand    = '0;
    next_id = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx  = (int'(last_id) + i) % NUM_MASTERS;
      cand = ID_W'(idx);
      if (!hit && bus.s_wb_stb_i[cand]) begin
        hit     = 1'b1;
        next_id = cand;
      end
    end
  end

  // Gating with reset kills the grant (and any ack) in the very cycle reset is seen.
  assign busy     = grant_valid & ~reset;
  assign lane     = busy ? grant_id : '0;
  assign lane_stb = busy & bus.s_wb_stb_i[grant_id];
  assign real_ack = lane_stb & bus.m_wb_ack_i;

`ifdef JELLY2_WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  assign fire = lane_stb & ~bus.m_wb_ack_i & (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign fire = 1'b0;
`endif

  assign done    = real_ack | fire;
  assign timeout = fire;

  assign bus.m_wb_adr_o = bus.s_wb_adr_i[lane];
  assign bus.m_wb_dat_o = bus.s_wb_dat_i[lane];
  assign bus.m_wb_we_o  = bus.s_wb_we_i[lane];
  assign bus.m_wb_sel_o = bus.s_wb_sel_i[lane];
  assign bus.m_wb_stb_o = lane_stb & ~fire;
  assign bus.s_wb_dat_o = fire ? '1 : bus.m_wb_dat_i;
  assign bus.s_wb_ack_o = done ? (NUM_MASTERS'(1) << grant_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_id     <= ID_W'(NUM_MASTERS - 1);
`ifdef JELLY2_WB_ARB_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef JELLY2_WB_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
          if (|bus.s_wb_stb_i) begin
            state       <= BUSY;
            grant_valid <= 1'b1;
            grant_id    <= next_id;
          end
        end
        BUSY: begin
`ifdef JELLY2_WB_ARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          if (done) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            last_id     <= grant_id;
          end else if (!bus.s_wb_stb_i[grant_id]) begin
            // Abort: the master withdrew, so it keeps its place in the rotation.
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jelly2_wishbone_rr_arbiter.sv
// Directed bench for the round-robin WISHBONE arbiter: single, contention, wait states,
// abort/reset and watchdog scenarios with hand-computed expectations.
module tb_jelly2_wishbone_rr_arbiter;
  localparam int NM = 2;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic                  clk;
  logic                  reset;
  logic                  grant_valid;
  logic [$clog2(NM)-1:0] grant_id;
  logic                  timeout;
  int                    n_cmp;
  int                    n_bad;

  jelly2_wishbone_rr_arbiter_if #(
    .NUM_MASTERS(NM), .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW)
  ) bus ();

  jelly2_wishbone_rr_arbiter #(
    .NUM_MASTERS(NM), .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .reset(reset), .clk(clk), .bus(bus),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.s_wb_stb_i = '0; bus.s_wb_we_i = '0; bus.s_wb_adr_i = '0;
    bus.s_wb_dat_i = '0; bus.s_wb_sel_i = '0;
    bus.m_wb_ack_i = 1'b0; bus.m_wb_dat_i = '0;
    next_cycle; next_cycle;
    settle;
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    n_cmp++; if (bus.s_wb_ack_o !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", bus.s_wb_ack_o); end
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", bus.m_wb_stb_o); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    next_cycle;
    reset = 1'b0;
    next_cycle;
  endtask

  task automatic test_single;
    bus.s_wb_stb_i = 2'b10; bus.s_wb_we_i = 2'b00;
    bus.s_wb_adr_i[1] = 27'h10000; bus.m_wb_dat_i = 32'h1; bus.m_wb_ack_i = 1'b1;
    settle;
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL single_idle_stb: got %b want 0", bus.m_wb_stb_o); end
    n_cmp++; if (bus.s_wb_ack_o !== 2'b00) begin n_bad++; $display("FAIL single_idle_ack: got %b want 00", bus.s_wb_ack_o); end
    next_cycle;
    settle;
    n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 1'b1) begin n_bad++; $display("FAIL single_grant: got gv=%b id=%0d want gv=1 id=1", grant_valid, grant_id); end
    n_cmp++; if (bus.s_wb_ack_o !== 2'b10) begin n_bad++; $display("FAIL single_ack: got %b want 10", bus.s_wb_ack_o); end
    n_cmp++; if (bus.s_wb_dat_o !== 32'h1) begin n_bad++; $display("FAIL single_rdata: got %h want 00000001", bus.s_wb_dat_o); end
    n_cmp++; if (bus.m_wb_adr_o !== 27'h10000 || bus.m_wb_stb_o !== 1'b1) begin n_bad++; $display("FAIL single_fwd: got adr=%h stb=%b want adr=0010000 stb=1", bus.m_wb_adr_o, bus.m_wb_stb_o); end
    next_cycle;
    bus.s_wb_stb_i = 2'b00;
    settle;
    n_cmp++; if (grant_valid !== 1'b0 || bus.s_wb_ack_o !== 2'b00) begin n_bad++; $display("FAIL single_after: got gv=%b ack=%b want gv=0 ack=00", grant_valid, bus.s_wb_ack_o); end
    bus.m_wb_ack_i = 1'b0;
    next_cycle;
  endtask

  task automatic test_contention;
    logic [1:0] exp_ack [8];
    exp_ack = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    bus.s_wb_stb_i = 2'b11; bus.m_wb_ack_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle;
      n_cmp++; if (bus.s_wb_ack_o !== exp_ack[c]) begin n_bad++; $display("FAIL contention_ack[%0d]: got %b want %b", c, bus.s_wb_ack_o, exp_ack[c]); end
      if (c % 2 == 1) begin
        n_cmp++; if (grant_id !== 1'((c / 2) % 2)) begin n_bad++; $display("FAIL contention_gid[%0d]: got %0d want %0d", c, grant_id, (c / 2) % 2); end
      end
      next_cycle;
    end
    bus.s_wb_stb_i = 2'b00; bus.m_wb_ack_i = 1'b0;
    settle;
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL contention_end: got %b want 0", grant_valid); end
    next_cycle;
  endtask

  task automatic test_wait_states;
    bus.s_wb_stb_i = 2'b11; bus.s_wb_we_i = 2'b01;
    bus.s_wb_dat_i[0] = 32'hA5A5A5A5; bus.s_wb_sel_i[0] = 4'hF;
    bus.s_wb_dat_i[1] = 32'h0; bus.s_wb_sel_i[1] = 4'h0; bus.m_wb_ack_i = 1'b0;
    settle;
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL wait_idle: got %b want 0", grant_valid); end
    next_cycle;
    for (int c = 1; c <= 4; c++) begin
      bus.m_wb_ack_i = (c == 4);
      settle;
      n_cmp++; if (bus.m_wb_dat_o !== 32'hA5A5A5A5 || bus.m_wb_stb_o !== 1'b1) begin n_bad++; $display("FAIL wait_fwd[%0d]: got dat=%h stb=%b want dat=a5a5a5a5 stb=1", c, bus.m_wb_dat_o, bus.m_wb_stb_o); end
      n_cmp++; if (bus.m_wb_we_o !== 1'b1 || bus.m_wb_sel_o !== 4'hF) begin n_bad++; $display("FAIL wait_we_sel[%0d]: got we=%b sel=%h want we=1 sel=f", c, bus.m_wb_we_o, bus.m_wb_sel_o); end
      n_cmp++; if (bus.s_wb_ack_o !== ((c == 4) ? 2'b01 : 2'b00)) begin n_bad++; $display("FAIL wait_ack[%0d]: got %b want %b", c, bus.s_wb_ack_o, (c == 4) ? 2'b01 : 2'b00); end
      next_cycle;
    end
    bus.s_wb_stb_i = 2'b10; bus.m_wb_ack_i = 1'b0;
    settle;
    n_cmp++; if (grant_valid !== 1'b0 || bus.s_wb_ack_o !== 2'b00) begin n_bad++; $display("FAIL wait_gap: got gv=%b ack=%b want gv=0 ack=00", grant_valid, bus.s_wb_ack_o); end
    next_cycle;
    bus.m_wb_ack_i = 1'b1;
    settle;
    n_cmp++; if (grant_id !== 1'b1 || bus.s_wb_ack_o !== 2'b10) begin n_bad++; $display("FAIL wait_next: got id=%0d ack=%b want id=1 ack=10", grant_id, bus.s_wb_ack_o); end
    next_cycle;
    bus.s_wb_stb_i = 2'b00; bus.m_wb_ack_i = 1'b0; bus.s_wb_we_i = 2'b00;
    settle;
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL wait_end: got %b want 0", grant_valid); end
    next_cycle;
  endtask

  task automatic test_abort_reset;
    bus.s_wb_stb_i = 2'b01; bus.m_wb_ack_i = 1'b0;
    next_cycle;
    settle;
    n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 1'b0) begin n_bad++; $display("FAIL abort_grant: got gv=%b id=%0d want gv=1 id=0", grant_valid, grant_id); end
    next_cycle;
    bus.s_wb_stb_i = 2'b00;
    settle;
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0 || bus.s_wb_ack_o !== 2'b00) begin n_bad++; $display("FAIL abort_drop: got stb=%b ack=%b want stb=0 ack=00", bus.m_wb_stb_o, bus.s_wb_ack_o); end
    next_cycle;
    settle;
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b want 0", grant_valid); end
    bus.s_wb_stb_i = 2'b11;
    next_cycle;
    // last_id must still be 1 after the abort, so master 0 wins again
    bus.m_wb_ack_i = 1'b1;
    settle;
    n_cmp++; if (grant_id !== 1'b0 || bus.s_wb_ack_o !== 2'b01) begin n_bad++; $display("FAIL abort_keep_rr: got id=%0d ack=%b want id=0 ack=01", grant_id, bus.s_wb_ack_o); end
    next_cycle;
    bus.s_wb_stb_i = 2'b10; bus.m_wb_ack_i = 1'b0;
    next_cycle;
    settle;
    n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 1'b1) begin n_bad++; $display("FAIL reset_pre: got gv=%b id=%0d want gv=1 id=1", grant_valid, grant_id); end
    next_cycle;
    reset = 1'b1; bus.m_wb_ack_i = 1'b1; bus.s_wb_stb_i = 2'b11;
    settle;
    n_cmp++; if (bus.s_wb_ack_o !== 2'b00) begin n_bad++; $display("FAIL reset_mid_ack: got %b want 00", bus.s_wb_ack_o); end
    next_cycle;
    reset = 1'b0; bus.m_wb_ack_i = 1'b0;
    settle;
    n_cmp++; if (grant_valid !== 1'b0 || grant_id !== 1'b0) begin n_bad++; $display("FAIL reset_mid_idle: got gv=%b id=%0d want gv=0 id=0", grant_valid, grant_id); end
    next_cycle;
    settle;
    n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 1'b0) begin n_bad++; $display("FAIL reset_first: got gv=%b id=%0d want gv=1 id=0", grant_valid, grant_id); end
    next_cycle;
    bus.s_wb_stb_i = 2'b00;
    next_cycle;
    next_cycle;
  endtask

  task automatic test_timeout;
    bus.s_wb_stb_i = 2'b11; bus.m_wb_ack_i = 1'b0; bus.m_wb_dat_i = 32'h12345678;
    next_cycle;
`ifdef JELLY2_WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      settle;
      if (c < 9) begin
        n_cmp++; if (bus.s_wb_ack_o !== 2'b00 || timeout !== 1'b0 || bus.m_wb_stb_o !== 1'b1) begin n_bad++; $display("FAIL to_wait[%0d]: got ack=%b to=%b stb=%b want ack=00 to=0 stb=1", c, bus.s_wb_ack_o, timeout, bus.m_wb_stb_o); end
      end else begin
        n_cmp++; if (bus.s_wb_ack_o !== 2'b01 || timeout !== 1'b1 || bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL to_fire: got ack=%b to=%b stb=%b want ack=01 to=1 stb=0", bus.s_wb_ack_o, timeout, bus.m_wb_stb_o); end
        n_cmp++; if (bus.s_wb_dat_o !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL to_rdata: got %h want ffffffff", bus.s_wb_dat_o); end
      end
      next_cycle;
    end
    settle;
    n_cmp++; if (grant_valid !== 1'b0 || timeout !== 1'b0) begin n_bad++; $display("FAIL to_after: got gv=%b to=%b want gv=0 to=0", grant_valid, timeout); end
    next_cycle;
    settle;
    n_cmp++; if (grant_valid !== 1'b1 || grant_id !== 1'b1) begin n_bad++; $display("FAIL to_next: got gv=%b id=%0d want gv=1 id=1", grant_valid, grant_id); end
`else
    for (int c = 1; c <= 12; c++) begin
      settle;
      n_cmp++; if (timeout !== 1'b0 || bus.s_wb_ack_o !== 2'b00 || grant_valid !== 1'b1) begin n_bad++; $display("FAIL to_off[%0d]: got to=%b ack=%b gv=%b want to=0 ack=00 gv=1", c, timeout, bus.s_wb_ack_o, grant_valid); end
      next_cycle;
    end
`endif
    bus.s_wb_stb_i = 2'b00;
    next_cycle;
    next_cycle;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_single;
    test_contention;
    test_wait_states;
    test_abort_reset;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jelly2_wishbone_rr_arbiter.md
# jelly2_wishbone_rr_arbiter

Round-robin arbiter that shares one WISHBONE peripheral bus among several WISHBONE masters. Typical masters are the AXI4-Lite bridge and a hardware sequencer. The single master port drives the existing address decode, which routes to the RTOS core, LED and interval timer slaves. The arbiter grants one master at a time and holds the grant until that transfer completes. An optional watchdog terminates transfers to a slave that never acknowledges.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- WB_ADR_WIDTH, 27, word address width
- WB_DAT_WIDTH, 32, data width
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte select width
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles (only used with the macro)

Ports:
- reset  in  1  reset, synchronous, active-high
- clk  in  1  clock clk
- s_wb_adr_i  in  NUM_MASTERS×WB_ADR_WIDTH  per-master address
- s_wb_dat_i  in  NUM_MASTERS×WB_DAT_WIDTH  per-master write data
- s_wb_dat_o  out  WB_DAT_WIDTH  read data, broadcast to all masters
- s_wb_we_i  in  NUM_MASTERS  per-master write enable
- s_wb_sel_i  in  NUM_MASTERS×WB_SEL_WIDTH  per-master byte select
- s_wb_stb_i  in  NUM_MASTERS  per-master strobe (request)
- s_wb_ack_o  out  NUM_MASTERS  per-master acknowledge, one-hot or zero
- m_wb_adr_o / m_wb_dat_o / m_wb_we_o / m_wb_sel_o / m_wb_stb_o  out  master-port signals, same widths as one s_ lane
- m_wb_dat_i  in  WB_DAT_WIDTH  slave read data
- m_wb_ack_i  in  1  slave acknowledge
- grant_valid  out  1  a grant is held
- grant_id  out  $clog2(NUM_MASTERS)  index of the granted master
- timeout  out  1  one-cycle pulse when the watchdog fires; tied 0 without the macro

## Operation
- FSM states:
  - IDLE: no grant held.
  - BUSY: grant_id is granted.
- IDLE:
  - If no s_wb_stb_i bit is set, stay in IDLE.
  - Otherwise scan from (last_id+1) mod NUM_MASTERS upward, with wrap-around, and select the first master with its strobe set.
  - Register that master as grant_id and enter BUSY.
- BUSY, forwarding:
  - m_wb_adr_o, m_wb_dat_o, m_wb_we_o and m_wb_sel_o follow lane grant_id combinationally.
  - m_wb_stb_o = s_wb_stb_i[grant_id].
- BUSY, completion:
  - When m_wb_stb_o & m_wb_ack_i, assert s_wb_ack_o[grant_id] in the same cycle.
  - Set last_id ← grant_id and return to IDLE.
- BUSY, abort: if s_wb_stb_i[grant_id] drops before ack, return to IDLE with no ack and leave last_id unchanged.
- Non-granted masters see ack=0 and keep their strobe asserted; requests are never lost.
- s_wb_dat_o = m_wb_dat_i at all times. Only the acked master samples it.
- In IDLE, m_wb_stb_o = 0 and the other m_ outputs follow lane 0.
- Reset:
  - State IDLE, grant_valid=0, grant_id=0, last_id=NUM_MASTERS-1, so master 0 wins first.
  - All acks 0, m_wb_stb_o=0, timeout=0.
- Reset asserted mid-transfer drops the grant immediately. No ack is issued on that cycle.

## Timing
- Arbitration latency is 1 cycle.
  - A strobe first seen in IDLE at cycle N gives grant_valid=1 and m_wb_stb_o=1 at N+1.
  - A zero-wait slave acks at N+1, so s_wb_ack_o is high at N+1.
- After an ack the FSM spends at least one cycle in IDLE. Minimum transfer period is 2 cycles per access.
- A master holding its strobe after ack is treated as a new request and competes in round-robin order.
- Fairness: with all NUM_MASTERS strobes held, grants rotate 0,1,…,NUM_MASTERS-1,0. No master waits more than NUM_MASTERS transfers.
- Simultaneous strobes in IDLE are resolved solely by rotating priority from last_id+1.

## Configuration
- JELLY2_WB_ARB_TIMEOUT_EN defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When the counter equals TIMEOUT_CYCLES:
    - force m_wb_stb_o=0;
    - assert s_wb_ack_o[grant_id]=1 with s_wb_dat_o all ones;
    - pulse timeout for 1 cycle;
    - set last_id ← grant_id and return to IDLE.
  - A real ack in the same cycle takes precedence: normal completion, no timeout.
- Macro undefined: no counter is built, timeout is constant 0, and BUSY waits indefinitely for ack.

## Test plan
- Single request: master 1 strobes a read of adr 0x10000 while the slave returns 0x1 with zero wait. Required: grant_id=1 and ack[1]=1 one cycle after strobe, s_wb_dat_o=0x1, and ack[0] stays 0.
- Contention: masters 0 and 1 hold strobes for 4 transfers. Required: grant order 0,1,0,1 and exactly one ack every 2 cycles.
- Wait states: the slave delays ack by 3 cycles while master 0 writes 0xA5A5A5A5 with sel=0xF. Required: m_wb_dat_o is stable at 0xA5A5A5A5 and m_wb_stb_o=1 for 4 cycles, ack[0]=1 only on the 4th cycle, and master 1 gets no ack meanwhile.
- Abort and reset: the granted master drops its strobe before ack, then another transfer is reset mid-BUSY. Required: both return to IDLE with no ack, and after reset master 0 wins when both masters strobe.
- Timeout (with macro, TIMEOUT_CYCLES=8): the slave never acks. Required: on the 9th BUSY cycle ack=1, s_wb_dat_o=0xFFFFFFFF, timeout pulses once, and the next master is granted afterwards.
